// File: rtl/mips_mem_responder.sv
// Shared instruction/data memory for the 5-stage MIPS core: one-cycle registered reads,
// write-first collision handling, zero-fill after reset, and a sticky illegal-access flag.
module mips_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_ren,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_data,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        busy,
  output logic        addr_err,
  output logic [31:0] err_addr
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {ST_RESET, ST_CLEAR, ST_READY} state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_clr_ptr;
  logic [31:0]           r_mem [DEPTH];
  logic [31:0]           r_inst_data, r_mem_din, r_err_addr;
  logic                  r_addr_err;

  logic                  w_clearing, w_ready, w_clr_last;
  logic                  w_i_legal, w_d_legal, w_i_ill, w_d_ill, w_wr;
  logic [ADDR_WIDTH-1:0] w_i_idx, w_d_idx;
  logic [31:0]           w_i_rdata, w_d_rdata;

  assign w_clr_last = (r_clr_ptr == {ADDR_WIDTH{1'b1}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_RESET;
    else     r_state <= w_state_nxt;
  end

  // The RESET state already writes word 0, so CLEAR covers exactly DEPTH edges.
  always_comb begin
    w_state_nxt = r_state;
    w_clearing  = 1'b0;
    w_ready     = 1'b0;
    case (r_state)
      ST_RESET: begin
        if (INIT_CLEAR) begin
          w_clearing  = 1'b1;
          w_state_nxt = w_clr_last ? ST_READY : ST_CLEAR;
        end else begin
          w_ready     = 1'b1;
          w_state_nxt = ST_READY;
        end
      end
      ST_CLEAR: begin
        w_clearing = 1'b1;
        if (w_clr_last) w_state_nxt = ST_READY;
      end
      ST_READY: w_ready = 1'b1;
      default:  w_state_nxt = ST_RESET;
    endcase
  end

  assign busy = INIT_CLEAR && (r_state != ST_READY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_clr_ptr <= '0;
    else if (w_clearing) r_clr_ptr <= r_clr_ptr + ADDR_WIDTH'(1);
  end

  assign w_i_legal = (inst_addr[1:0] == 2'b00) && ((inst_addr >> (ADDR_WIDTH + 2)) == 32'd0);
  assign w_d_legal = (mem_addr[1:0] == 2'b00) && ((mem_addr >> (ADDR_WIDTH + 2)) == 32'd0);
  assign w_i_idx   = inst_addr[ADDR_WIDTH+1:2];
  assign w_d_idx   = mem_addr[ADDR_WIDTH+1:2];
  assign w_i_ill   = inst_ren && !w_i_legal;
  assign w_d_ill   = (mem_ren || mem_wen) && !w_d_legal;
  assign w_wr      = w_ready && mem_wen && w_d_legal;

  always_ff @(posedge clk) begin
    if (w_clearing) r_mem[r_clr_ptr] <= '0;
    else if (w_wr)  r_mem[w_d_idx]   <= mem_dout;
  end

  // Write-first: a same-cycle store bypasses the array onto either read port.
  assign w_i_rdata = (w_wr && (w_d_idx == w_i_idx)) ? mem_dout : r_mem[w_i_idx];
  assign w_d_rdata = w_wr ? mem_dout : r_mem[w_d_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inst_data <= '0;
      r_mem_din   <= '0;
      r_addr_err  <= 1'b0;
      r_err_addr  <= '0;
    end else if (!w_ready) begin
      r_inst_data <= '0;
      r_mem_din   <= '0;
    end else begin
      if (inst_ren) r_inst_data <= w_i_legal ? w_i_rdata : 32'd0;
      if (mem_ren)  r_mem_din   <= w_d_legal ? w_d_rdata : 32'd0;
      if (w_i_ill || w_d_ill) begin
        r_addr_err <= 1'b1;
        if (!r_addr_err) r_err_addr <= w_d_ill ? mem_addr : inst_addr;
      end
    end
  end

  assign inst_data = r_inst_data;
  assign mem_din   = r_mem_din;
  assign addr_err  = r_addr_err;
  assign err_addr  = r_err_addr;
endmodule

// File: tb/tb_mips_mem_responder.sv
// Randomised and directed bench for mips_mem_responder (ADDR_WIDTH=4) against a
// transaction-level memory model.
module tb_mips_mem_responder;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_ren = 1'b0;
  logic [31:0] inst_addr = '0;
  logic [31:0] inst_data;
  logic        mem_ren = 1'b0;
  logic        mem_wen = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_dout = '0;
  logic [31:0] mem_din;
  logic        busy;
  logic        addr_err;
  logic [31:0] err_addr;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  logic [31:0] m_mem [DEPTH];
  logic [31:0] e_inst, e_din, e_eaddr;
  logic        e_err;
  int          clr_left;

  mips_mem_responder #(.ADDR_WIDTH(AW), .INIT_CLEAR(1'b1)) dut (
    .clk(clk), .rst(rst),
    .inst_ren(inst_ren), .inst_addr(inst_addr), .inst_data(inst_data),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_dout(mem_dout), .mem_din(mem_din),
    .busy(busy), .addr_err(addr_err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit legal(input logic [31:0] a);
    return (a % 4 == 0) && (a < 4 * DEPTH);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a / 4) % DEPTH;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, clr_left != 0});
    chk({tag, ".inst_data"}, inst_data, e_inst);
    chk({tag, ".mem_din"}, mem_din, e_din);
    chk({tag, ".addr_err"}, {31'd0, addr_err}, {31'd0, e_err});
    chk({tag, ".err_addr"}, err_addr, e_eaddr);
  endtask

  // Reset asserted mid-cycle; outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    e_inst = '0; e_din = '0; e_err = 1'b0; e_eaddr = '0;
    clr_left = DEPTH;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock: predict from the sampled inputs, clock, then compare.
  task automatic cyc(input string tag);
    bit ill_i, ill_d;
    if (clr_left != 0) begin
      clr_left--;
    end else begin
      if (mem_wen && legal(mem_addr)) m_mem[widx(mem_addr)] = mem_dout;
      if (inst_ren) e_inst = legal(inst_addr) ? m_mem[widx(inst_addr)] : 32'd0;
      if (mem_ren)  e_din  = legal(mem_addr)  ? m_mem[widx(mem_addr)]  : 32'd0;
      ill_i = inst_ren && !legal(inst_addr);
      ill_d = (mem_ren || mem_wen) && !legal(mem_addr);
      if ((ill_i || ill_d) && !e_err) e_eaddr = ill_d ? mem_addr : inst_addr;
      if (ill_i || ill_d) e_err = 1'b1;
    end
    @(posedge clk);
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic mr,
                       input logic mw, input logic [31:0] ma, input logic [31:0] md);
    inst_ren = ir; inst_addr = ia; mem_ren = mr; mem_wen = mw; mem_addr = ma; mem_dout = md;
  endtask

  function automatic logic [31:0] rnd_addr();
    int r;
    r = $urandom_range(0, 19);
    if (r < 17)       return 32'($urandom_range(0, DEPTH - 1)) * 4;
    else if (r == 17) return 32'($urandom_range(0, 4 * DEPTH - 1)) | 32'd1;
    else              return 32'h40 + 32'($urandom_range(0, 1000)) * 4;
  endfunction

  task automatic rnd_inputs();
    drive(1'($urandom_range(0, 1)), rnd_addr(), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), rnd_addr(), $urandom);
  endtask

  initial begin
    do_reset();
    // Reset partway through CLEAR restarts the full fill.
    for (int i = 0; i < 7; i++) begin rnd_inputs(); cyc("clear_a"); end
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 3) drive(1'b1, 32'h401, 1'b0, 1'b1, 32'h04, 32'hAAAA5555);
      else        rnd_inputs();
      cyc("clear_b");
    end
    drive(1'b0, 0, 1'b1, 1'b0, 32'h04, 0);           cyc("busy_drop");
    drive(1'b1, 32'h3C, 1'b1, 1'b0, 32'h3C, 0);      cyc("read_top");
    drive(1'b0, 0, 1'b0, 1'b1, 32'h08, 32'hDEADBEEF); cyc("store");
    drive(1'b1, 32'h08, 1'b1, 1'b0, 32'h08, 0);      cyc("load");
    drive(1'b1, 32'h10, 1'b0, 1'b1, 32'h10, 32'h12345678); cyc("collide_i");
    drive(1'b0, 0, 1'b1, 1'b1, 32'h14, 32'hCAFEF00D); cyc("collide_d");
    drive(1'b0, 0, 1'b0, 1'b1, 32'h0A, 32'hFFFFFFFF); cyc("misalign");
    drive(1'b1, 32'h08, 1'b1, 1'b0, 32'h08, 0);      cyc("after_mis");
    drive(1'b0, 0, 1'b1, 1'b0, 32'h400, 0);          cyc("second_err");
    drive(1'b0, 0, 1'b0, 1'b0, 0, 0);                cyc("idle_hold");
    for (int i = 0; i < 300; i++) begin rnd_inputs(); cyc("rand"); end
    // Reset from READY with live outputs, then a dual-port error right after fill.
    drive(1'b1, 32'h0C, 1'b1, 1'b0, 32'h18, 0);      cyc("pre_rst");
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin rnd_inputs(); cyc("clear_c"); end
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 32'(i) * 4, 1'b1, 1'b0, 32'(DEPTH - 1 - i) * 4, 0);
      cyc("zero_chk");
    end
    drive(1'b1, 32'h401, 1'b1, 1'b0, 32'h07, 0);     cyc("dual_err");
    drive(1'b1, 32'h002, 1'b0, 1'b0, 0, 0);          cyc("err_sticky");
    for (int i = 0; i < 100; i++) begin rnd_inputs(); cyc("rand2"); end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mips_mem_responder.md
# mips_mem_responder

Memory-side responder for the 5-stage MIPS core's instruction and data interfaces. It serves instruction fetches and data loads and stores from one word-organised internal RAM. Read latency is a fixed one cycle. After every reset it zero-fills the RAM with an initialisation state machine, and it flags illegal accesses with a sticky error. It sits between `mips_core` and the board top, in place of separate instruction and data memories.

## Interface
Parameters:
- `ADDR_WIDTH`, default 10: word-address width; the RAM holds DEPTH = 2^ADDR_WIDTH 32-bit words.
- `INIT_CLEAR`, default 1: 1 = zero-fill the RAM after reset; 0 = ready immediately after reset.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1: main clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `inst_ren`  in  1: instruction read request.
- `inst_addr`  in  32: instruction byte address.
- `inst_data`  out  32: instruction returned to the core.
- `mem_ren`  in  1: data read request.
- `mem_wen`  in  1: data write request.
- `mem_addr`  in  32: data byte address.
- `mem_dout`  in  32: store data driven by the core.
- `mem_din`  out  32: load data returned to the core.
- `busy`  out  1: initialisation in progress; all requests are ignored.
- `addr_err`  out  1: sticky illegal-access flag.
- `err_addr`  out  32: byte address of the first illegal access.

## Operation
- Word index = addr[ADDR_WIDTH+1:2].
- An access is legal when addr[1:0] == 0 and addr[31:ADDR_WIDTH+2] == 0.
- FSM states:
  - RESET: asynchronous entry on `rst`.
  - CLEAR: zero-fill in progress.
  - READY: normal service.
- Transitions:
  - On `rst` deassert: go to CLEAR if INIT_CLEAR=1, else READY.
  - CLEAR: an ADDR_WIDTH-bit counter `clr_ptr` starts at 0 and writes zero to RAM[clr_ptr] each cycle. After writing DEPTH-1 (the counter wraps to 0), go to READY.
  - READY is held until reset.
- While `busy`=1:
  - core requests are not serviced; writes are dropped;
  - `inst_data`/`mem_din` hold 0;
  - `addr_err` is not updated.
- READY, instruction port: when `inst_ren`=1 and the address is legal, RAM[idx] is registered onto `inst_data`.
- READY, data read: when `mem_ren`=1 and the address is legal, RAM[idx] is registered onto `mem_din`.
- READY, data write: when `mem_wen`=1 and the address is legal, `mem_dout` is written to RAM[idx] at the edge.
- Write-first collision rule: if a write and a read (either port) target the same word in the same cycle, the read returns the newly written `mem_dout`.
- `mem_ren` and `mem_wen` both high to the same address: the write happens, and `mem_din` returns `mem_dout`.
- Read-enable low: the corresponding output holds its previous value.
- Illegal access (any port whose enable is high):
  - a read returns 0 on its output;
  - a write is suppressed;
  - `addr_err` is set.
- `err_addr` capture:
  - The first illegal address is captured only when `addr_err` was 0.
  - If both ports are illegal in the same cycle, the data-port address is captured.
  - Later errors do not overwrite it.
  - Only reset clears `addr_err`.

## Timing
- Reset values:
  - `inst_data`=0, `mem_din`=0, `addr_err`=0, `err_addr`=0, `clr_ptr`=0.
  - `busy`=1 if INIT_CLEAR=1, else 0.
- RAM contents are not reset asynchronously; only CLEAR zeroes them.
- CLEAR lasts exactly DEPTH cycles:
  - The first rising edge after `rst` falls writes word 0.
  - The edge that writes word DEPTH-1 also drops `busy`.
- The first request serviced is the one sampled on the edge after `busy` is seen low.
- Read latency: a request sampled at edge N has its data valid on the output after edge N, and the output is stable until the next serviced read. It is a single registered output, so the read path is a synchronous RAM.
- Write latency: a write sampled at edge N is visible to any read sampled at edge N (write-first) or later.
- `addr_err`/`err_addr` update at the same edge that samples the illegal request.
- Reset mid-CLEAR or mid-READY: outputs and `clr_ptr` return to their reset values immediately, and CLEAR restarts from word 0.
- Throughput: one instruction read plus one data access every cycle, with no stalls after initialisation.

## Test plan
- Init, ADDR_WIDTH=4: pulse `rst`, then release. Required: `busy`=1 for exactly 16 cycles then 0; a subsequent read of 0x3C returns 0x00000000.
- Store/load: write 0xDEADBEEF to 0x08, then `mem_ren` at 0x08 on the next cycle. Required: `mem_din`=0xDEADBEEF one edge after the read is sampled; `inst_ren` at 0x08 also returns 0xDEADBEEF.
- Collision: in one cycle, `mem_wen` to 0x10 with 0x12345678 plus `inst_ren` at 0x10. Required: `inst_data`=0x12345678 after that edge.
- Misaligned: `mem_wen` at 0x0A with 0xFFFFFFFF, then read 0x08. Required: `addr_err`=1, `err_addr`=0x0000000A, read returns the old value. A second illegal access at 0x400 leaves `err_addr`=0x0000000A.
- Busy drop: issue `mem_wen` at 0x04 with 0xAAAA5555 during CLEAR, then read 0x04 once READY. Required: returns 0; `addr_err` stays 0.
- Reset mid-CLEAR: assert `rst` at cycle 7 of CLEAR, then release. Required: outputs are 0 immediately; `busy` lasts a full 16 cycles again.
